// File: rtl/fib_pkg.sv
// Shared constants and FSM state encoding for the Fibonacci-style LIFO stack controller.
package fib_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Occupancy counter needs one extra bit so it can represent DEPTH itself.
  function automatic int sp_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stack_mem.sv
// DEPTH x WIDTH register file: synchronous write, combinational indexed read, no reset.
module stack_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fib_stack_ctrl.sv
// LIFO stack controller: request handshake FSM, saturating stack pointer and sticky error flags.
//   state    | meaning
//   ST_IDLE  | waiting for a request; push wins over pop
//   ST_WRITE | store din at mem[sp] and bump sp, or flag overflow when full
//   ST_READ  | load dout from mem[sp-1] and drop sp, or flag underflow when empty
//   ST_DONE  | one-cycle readySig pulse, then back to idle
module fib_stack_ctrl
  import fib_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pushSig,
  input  logic                     popSig,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     readySig,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf,
  output logic                     udf,
  output logic [$clog2(DEPTH):0]   sp
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
  localparam logic [AW-1:0]  AD_ONE  = AW'(1);

  state_e state_q, state_d;

  logic [SPW-1:0]   sp_q, sp_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             full_w, empty_w;
  logic             ready_w;
  logic             mem_we_w;
  logic             do_pop_w;
  logic             set_ovf_w;
  logic             set_udf_w;
  logic [AW-1:0]    waddr_w;
  logic [AW-1:0]    raddr_w;
  logic [WIDTH-1:0] rdata_w;

  assign full_w  = (sp_q == SP_FULL);
  assign empty_w = (sp_q == '0);

  // When full the low pointer bits wrap to zero, so sp-1 on those bits still names the top entry.
  assign waddr_w = sp_q[AW-1:0];
  assign raddr_w = sp_q[AW-1:0] - AD_ONE;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pushSig) begin
          state_d = ST_WRITE;
        end else if (popSig) begin
          state_d = ST_READ;
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_READ:  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    ready_w   = 1'b0;
    mem_we_w  = 1'b0;
    do_pop_w  = 1'b0;
    set_ovf_w = 1'b0;
    set_udf_w = 1'b0;
    case (state_q)
      ST_WRITE: begin
        mem_we_w  = ~full_w;
        set_ovf_w = full_w;
      end
      ST_READ: begin
        do_pop_w  = ~empty_w;
        set_udf_w = empty_w;
      end
      ST_DONE: ready_w = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    sp_d   = sp_q;
    dout_d = dout_q;
    ovf_d  = ovf_q | set_ovf_w;
    udf_d  = udf_q | set_udf_w;
    if (mem_we_w) begin
      sp_d = sp_q + SP_ONE;
    end else if (do_pop_w) begin
      sp_d   = sp_q - SP_ONE;
      dout_d = rdata_w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q   <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_stack_mem (
    .clk     (clk),
    .we_i    (mem_we_w),
    .waddr_i (waddr_w),
    .wdata_i (din),
    .raddr_i (raddr_w),
    .rdata_o (rdata_w)
  );

  assign dout     = dout_q;
  assign readySig = ready_w;
  assign full     = full_w;
  assign empty    = empty_w;
  assign ovf      = ovf_q;
  assign udf      = udf_q;
  assign sp       = sp_q;

endmodule

// File: tb/tb_fib_stack_ctrl.sv
// Scoreboard bench for fib_stack_ctrl: a queue-based LIFO model predicts each completion.
module tb_fib_stack_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pushSig = 1'b0;
  logic             popSig = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic             readySig;
  logic             full, empty, ovf, udf;
  logic [4:0]       sp;

  fib_stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .pushSig  (pushSig),
    .popSig   (popSig),
    .din      (din),
    .dout     (dout),
    .readySig (readySig),
    .full     (full),
    .empty    (empty),
    .ovf      (ovf),
    .udf      (udf),
    .sp       (sp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] dout;
    int         sp;
    bit         ovf;
    bit         udf;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mstk[$];
  logic [7:0] mdout = 8'h00;
  bit         movf = 1'b0;
  bit         mudf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mstk.delete();
    mdout = 8'h00;
    movf  = 1'b0;
    mudf  = 1'b0;
  endtask

  // Push wins over pop; full/empty requests only raise the sticky flags.
  task automatic model_apply(input bit p, input bit q, input logic [7:0] d, input int ecyc);
    exp_t e;
    if (p) begin
      if (mstk.size() < DEPTH) mstk.push_back(d);
      else movf = 1'b1;
    end else if (q) begin
      if (mstk.size() > 0) mdout = mstk.pop_back();
      else mudf = 1'b1;
    end
    e.dout = mdout;
    e.sp   = mstk.size();
    e.ovf  = movf;
    e.udf  = mudf;
    e.cyc  = ecyc;
    sb.push_back(e);
  endtask

  // Monitor: every readySig pulse retires exactly one scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && readySig) begin
        if (sb.size() == 0) begin
          chk("ready_unexpected", 32'(readySig), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("dout",    32'(dout),  32'(e.dout));
          chk("sp",      32'(sp),    32'(e.sp));
          chk("ovf",     32'(ovf),   32'(e.ovf));
          chk("udf",     32'(udf),   32'(e.udf));
          chk("full",    32'(full),  32'(e.sp == DEPTH));
          chk("empty",   32'(empty), 32'(e.sp == 0));
          chk("latency", 32'(cyc),   32'(e.cyc));
        end
      end
    end
  end

  // Called at a negedge with the FSM idle; acceptance happens on the next rising edge.
  task automatic issue(input bit p, input bit q, input logic [7:0] d);
    pushSig = p;
    popSig  = q;
    din     = d;
    model_apply(p, q, d, cyc + 2);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (readySig) return;
    end
    chk("ready_timeout", 32'(readySig), 32'd1);
  endtask

  task automatic op(input bit p, input bit q, input logic [7:0] d);
    @(negedge clk);
    issue(p, q, d);
    wait_ready();
    pushSig = 1'b0;
    popSig  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_sp",    32'(sp),       32'd0);
    chk("rst_dout",  32'(dout),     32'd0);
    chk("rst_ready", 32'(readySig), 32'd0);
    chk("rst_ovf",   32'(ovf),      32'd0);
    chk("rst_udf",   32'(udf),      32'd0);
    chk("rst_empty", 32'(empty),    32'd1);
    chk("rst_full",  32'(full),     32'd0);
    rst = 1'b0;

    // Pop on empty after reset
    op(0, 1, 8'h00);

    do_reset();
    op(1, 0, 8'h05);
    op(1, 0, 8'h08);
    op(1, 0, 8'h0D);
    repeat (3) op(0, 1, 8'h00);

    // Fill to capacity, overflow, then pop the top
    do_reset();
    for (int i = 0; i < DEPTH; i++) op(1, 0, 8'(i));
    op(1, 0, 8'hFF);
    op(0, 1, 8'h00);

    // Simultaneous push and pop: push wins
    do_reset();
    op(1, 1, 8'h21);
    op(0, 1, 8'h00);

    // Reset during WRITE aborts with no pulse and clears flags
    op(0, 1, 8'h00);
    @(negedge clk);
    pushSig = 1'b1;
    din     = 8'h33;
    @(posedge clk);
    #2;
    rst     = 1'b1;
    pushSig = 1'b0;
    model_reset();
    #1;
    chk("abort_ready", 32'(readySig), 32'd0);
    chk("abort_sp",    32'(sp),       32'd0);
    chk("abort_ovf",   32'(ovf),      32'd0);
    chk("abort_udf",   32'(udf),      32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    op(1, 0, 8'h44);
    op(0, 1, 8'h00);

    // Push held across DONE with changing data
    do_reset();
    @(negedge clk);
    issue(1, 0, 8'h01);
    wait_ready();
    din = 8'h02;
    model_apply(1, 0, 8'h02, cyc + 3);
    wait_ready();
    pushSig = 1'b0;
    op(0, 1, 8'h00);
    op(0, 1, 8'h00);

    // Randomized traffic, biased so both full and empty get exercised
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (n % 100 < 50) begin
        if (kind < 6) op(1, 0, 8'($urandom));
        else if (kind < 9) op(0, 1, 8'($urandom));
        else op(1, 1, 8'($urandom));
      end else begin
        if (kind < 3) op(1, 0, 8'($urandom));
        else if (kind < 9) op(0, 1, 8'($urandom));
        else op(1, 1, 8'($urandom));
      end
    end

    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
